// File: rtl/dti_apb_pkg.sv
// Shared types for the core-memory to APB3 bridge: FSM state encoding and access-size codes.
package dti_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/dti_apb_lane_align.sv
// Combinational lane handling: write-data replication across byte lanes and
// read-data extraction with zero extension.
module dti_apb_lane_align
    import dti_apb_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rd_lanes,
    output logic [31:0] rd_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (wr_size)
            SIZE_BYTE: wr_lanes = {4{wr_data[7:0]}};
            SIZE_HALF: wr_lanes = {2{wr_data[15:0]}};
            default:   wr_lanes = wr_data;
        endcase
    end

    always_comb begin
        case (rd_offset)
            2'd0:    rd_byte = rd_lanes[7:0];
            2'd1:    rd_byte = rd_lanes[15:8];
            2'd2:    rd_byte = rd_lanes[23:16];
            default: rd_byte = rd_lanes[31:24];
        endcase
        rd_half = rd_offset[1] ? rd_lanes[31:16] : rd_lanes[15:0];
        case (rd_size)
            SIZE_BYTE: rd_data = {24'd0, rd_byte};
            SIZE_HALF: rd_data = {16'd0, rd_half};
            default:   rd_data = rd_lanes;
        endcase
    end

endmodule

// File: rtl/dti_apb_adapter.sv
// Single-outstanding bridge from the core memory request port to an APB3 master.
// Optional slave-error reporting (mem_error port) is enabled by DTI_APB_SLVERR_EN.
module dti_apb_adapter
    import dti_apb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_data_in,
    input  logic [1:0]  mem_data_size,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    output logic [31:0] mem_data_out,
    output logic        mem_read_ack,
    output logic        mem_write_ack,
`ifdef DTI_APB_SLVERR_EN
    output logic        mem_error,
`endif
    output logic [31:0] apb_paddr,
    output logic        apb_psel,
    output logic        apb_penable,
    output logic        apb_pwrite,
    output logic [31:0] apb_pwdata,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready,
    input  logic        apb_pslverr
);

    apb_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [31:0] rdata_q;
    logic        read_ack_q;
    logic        write_ack_q;
    logic [31:0] wr_lanes;
    logic [31:0] rd_data;
    logic        accept;
    logic        complete;
    logic        rd_err;

    dti_apb_lane_align u_align (
        .wr_size   (mem_data_size),
        .wr_data   (mem_data_in),
        .wr_lanes  (wr_lanes),
        .rd_size   (size_q),
        .rd_offset (addr_q[1:0]),
        .rd_lanes  (apb_prdata),
        .rd_data   (rd_data)
    );

    assign accept   = (state_q == IDLE) && (mem_read_req || mem_write_req);
    assign complete = (state_q == ACCESS) && apb_pready;

`ifdef DTI_APB_SLVERR_EN
    logic err_q;
    assign rd_err    = apb_pslverr;
    assign mem_error = err_q;
`else
    logic unused_pslverr;
    assign unused_pslverr = apb_pslverr;
    assign rd_err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb_pready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rdata_q     <= '0;
            read_ack_q  <= 1'b0;
            write_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_ack_q  <= complete && !pwrite_q;
            write_ack_q <= complete && pwrite_q;
            if (accept) begin
                // Write wins when both requests arrive together.
                addr_q   <= mem_address;
                size_q   <= mem_data_size;
                pwrite_q <= mem_write_req;
                if (mem_write_req) pwdata_q <= wr_lanes;
            end
            if (complete && !pwrite_q) rdata_q <= rd_err ? 32'd0 : rd_data;
        end
    end

`ifdef DTI_APB_SLVERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= complete && apb_pslverr;
    end
`endif

    assign apb_paddr     = addr_q;
    assign apb_psel      = (state_q != IDLE);
    assign apb_penable   = (state_q == ACCESS);
    assign apb_pwrite    = pwrite_q;
    assign apb_pwdata    = pwdata_q;
    assign mem_data_out  = rdata_q;
    assign mem_read_ack  = read_ack_q;
    assign mem_write_ack = write_ack_q;

endmodule

// File: tb/tb_dti_apb_adapter.sv
// Directed bench for dti_apb_adapter: vector table of single transfers plus
// hand sequences for collisions, back-to-back requests and mid-transfer reset.
module tb_dti_apb_adapter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_data_in = '0;
    logic [1:0]  mem_data_size = '0;
    logic        mem_read_req = 1'b0;
    logic        mem_write_req = 1'b0;
    logic [31:0] mem_data_out;
    logic        mem_read_ack;
    logic        mem_write_ack;
    logic [31:0] apb_paddr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata = '0;
    logic        apb_pready = 1'b0;
    logic        apb_pslverr = 1'b0;
`ifdef DTI_APB_SLVERR_EN
    logic        mem_error;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    dti_apb_adapter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_data_size (mem_data_size),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_data_out  (mem_data_out),
        .mem_read_ack  (mem_read_ack),
        .mem_write_ack (mem_write_ack),
`ifdef DTI_APB_SLVERR_EN
        .mem_error     (mem_error),
`endif
        .apb_paddr     (apb_paddr),
        .apb_psel      (apb_psel),
        .apb_penable   (apb_penable),
        .apb_pwrite    (apb_pwrite),
        .apb_pwdata    (apb_pwdata),
        .apb_prdata    (apb_prdata),
        .apb_pready    (apb_pready),
        .apb_pslverr   (apb_pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] prdata;
        int          waits;
        logic [31:0] exp_pwdata;
        logic [31:0] exp_rdata;
    } xfer_t;

    xfer_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transfer; returns at the negedge of the ack cycle.
    task automatic run_vec(input xfer_t v, input int idx);
        @(negedge clk);
        chk("ack_lo", {30'd0, mem_read_ack, mem_write_ack}, 32'd0);
        mem_address   = v.addr;
        mem_data_in   = v.data;
        mem_data_size = v.size;
        mem_write_req = v.wr;
        mem_read_req  = !v.wr;
        @(negedge clk);
        mem_write_req = 1'b0;
        mem_read_req  = 1'b0;
        chk("setup_sel_en", {30'd0, apb_psel, apb_penable}, 32'd2);
        chk("paddr", apb_paddr, v.addr);
        chk("pwrite", {31'd0, apb_pwrite}, {31'd0, v.wr});
        if (v.wr) chk("pwdata", apb_pwdata, v.exp_pwdata);
        for (int c = 0; c <= v.waits; c++) begin
            @(negedge clk);
            chk("access_sel_en", {30'd0, apb_psel, apb_penable}, 32'd3);
            chk("no_early_ack", {30'd0, mem_read_ack, mem_write_ack}, 32'd0);
            if (c == v.waits) begin
                apb_pready = 1'b1;
                apb_prdata = v.prdata;
            end
        end
        @(negedge clk);
        apb_pready = 1'b0;
        if (!v.wr) last_rd = v.exp_rdata;
        chk("ack", {30'd0, mem_read_ack, mem_write_ack}, v.wr ? 32'd1 : 32'd2);
        chk("idle_sel_en", {30'd0, apb_psel, apb_penable}, 32'd0);
        chk("data_out", mem_data_out, last_rd);
        chk("paddr_hold", apb_paddr, v.addr);
        $display("xfer %0d: %s addr=%h size=%0d waits=%0d pwdata=%h data_out=%h",
                 idx, v.wr ? "WR" : "RD", v.addr, v.size, v.waits, apb_pwdata, mem_data_out);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h100, 32'h0000_00AB, 2'b01, 32'h0,         0, 32'h00AB_00AB, 32'h0};
        vecs[1] = '{1'b0, 32'h200, 32'h0,         2'b10, 32'hDEAD_BEEF, 2, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h203, 32'h0,         2'b00, 32'h1122_3344, 0, 32'h0,         32'h0000_0011};
        vecs[3] = '{1'b1, 32'h007, 32'h1234_56C3, 2'b00, 32'h0,         1, 32'hC3C3_C3C3, 32'h0};
        vecs[4] = '{1'b0, 32'h302, 32'h0,         2'b01, 32'hCAFE_F00D, 0, 32'h0,         32'h0000_CAFE};
        vecs[5] = '{1'b0, 32'h300, 32'h0,         2'b01, 32'hCAFE_F00D, 1, 32'h0,         32'h0000_F00D};
        vecs[6] = '{1'b1, 32'h044, 32'h89AB_CDEF, 2'b11, 32'h0,         0, 32'h89AB_CDEF, 32'h0};
        vecs[7] = '{1'b0, 32'h401, 32'h0,         2'b00, 32'h1122_3344, 0, 32'h0,         32'h0000_0033};
        vecs[8] = '{1'b1, 32'h008, 32'h0102_0304, 2'b10, 32'h0,         3, 32'h0102_0304, 32'h0};

        repeat (2) @(negedge clk);
        chk("rst_sel_en", {30'd0, apb_psel, apb_penable}, 32'd0);
        chk("rst_paddr", apb_paddr, 32'd0);
        chk("rst_pwdata", apb_pwdata, 32'd0);
        chk("rst_data_out", mem_data_out, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Simultaneous read+write: write wins; a read pulse during ACCESS is dropped.
        @(negedge clk);
        mem_address = 32'h10; mem_data_in = 32'h55; mem_data_size = 2'b10;
        mem_write_req = 1'b1; mem_read_req = 1'b1;
        @(negedge clk);
        mem_write_req = 1'b0; mem_read_req = 1'b0;
        chk("coll_pwrite", {31'd0, apb_pwrite}, 32'd1);
        chk("coll_pwdata", apb_pwdata, 32'h55);
        @(negedge clk);
        mem_read_req = 1'b1; mem_address = 32'h999;
        @(negedge clk);
        mem_read_req = 1'b0;
        chk("coll_ignored_paddr", apb_paddr, 32'h10);
        apb_pready = 1'b1;
        @(negedge clk);
        apb_pready = 1'b0;
        chk("coll_ack", {30'd0, mem_read_ack, mem_write_ack}, 32'd1);
        $display("xfer coll: WR addr=%h pwdata=%h", apb_paddr, apb_pwdata);
        // Back-to-back: new request accepted in the ack cycle.
        mem_address = 32'h20; mem_data_size = 2'b10; mem_read_req = 1'b1;
        @(negedge clk);
        mem_read_req = 1'b0;
        chk("b2b_setup", {30'd0, apb_psel, apb_penable}, 32'd2);
        chk("b2b_pwrite", {31'd0, apb_pwrite}, 32'd0);
        apb_prdata = 32'h0BAD_F00D;
        apb_pready = 1'b1;
        @(negedge clk);
        chk("b2b_access", {30'd0, apb_psel, apb_penable}, 32'd3);
        @(negedge clk);
        apb_pready = 1'b0;
        chk("b2b_ack", {30'd0, mem_read_ack, mem_write_ack}, 32'd2);
        chk("b2b_data", mem_data_out, 32'h0BAD_F00D);
        $display("xfer b2b: RD addr=%h data_out=%h", apb_paddr, mem_data_out);
        @(negedge clk);
        chk("dropped_read", {30'd0, apb_psel, mem_read_ack, 1'b0}, 32'd0);

        // Reset in ACCESS aborts the transfer with no ack.
        mem_address = 32'h500; mem_data_in = 32'hFFFF; mem_data_size = 2'b01; mem_write_req = 1'b1;
        @(negedge clk);
        mem_write_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_access", {30'd0, apb_psel, apb_penable}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_sel_en", {30'd0, apb_psel, apb_penable}, 32'd0);
        chk("async_paddr", apb_paddr, 32'd0);
        chk("async_pwdata", apb_pwdata, 32'd0);
        chk("async_data_out", mem_data_out, 32'd0);
        apb_pready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ack", {30'd0, mem_read_ack, mem_write_ack}, 32'd0);
        end
        apb_pready = 1'b0;
        reset_n = 1'b1;
        last_rd = 32'd0;
        $display("xfer rst: aborted in ACCESS");
        run_vec(vecs[1], 9);

`ifdef DTI_APB_SLVERR_EN
        @(negedge clk);
        mem_address = 32'h600; mem_data_size = 2'b10; mem_read_req = 1'b1;
        @(negedge clk);
        mem_read_req = 1'b0;
        @(negedge clk);
        apb_prdata = 32'hFFFF_FFFF; apb_pslverr = 1'b1; apb_pready = 1'b1;
        @(negedge clk);
        apb_pready = 1'b0; apb_pslverr = 1'b0;
        chk("err_pulse", {30'd0, mem_error, mem_read_ack}, 32'd3);
        chk("err_data", mem_data_out, 32'd0);
        $display("xfer err: RD addr=%h data_out=%h", apb_paddr, mem_data_out);
        @(negedge clk);
        chk("err_one_cycle", {31'd0, mem_error}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dti_apb_adapter.md
# dti_apb_adapter

Bridges the core's simple memory request interface to an APB3 master port. It accepts a single-cycle read or write request, latches the request, and runs one APB transfer. It signals completion with a one-cycle acknowledge. It sits between the core's load/store path and the peripheral APB fabric.

## Interface
Parameters:
- none. Address and data widths are fixed at 32 bits.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- mem_address  in  32  request byte address.
- mem_data_in  in  32  write data, right-aligned.
- mem_data_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- mem_read_req  in  1  read request, one-cycle pulse.
- mem_write_req  in  1  write request, one-cycle pulse.
- mem_data_out  out  32  read data, right-aligned, zero-extended.
- mem_read_ack  out  1  read complete, one-cycle pulse.
- mem_write_ack  out  1  write complete, one-cycle pulse.
- apb_paddr  out  32  APB address.
- apb_psel  out  1  APB select.
- apb_penable  out  1  APB enable.
- apb_pwrite  out  1  APB direction; 1 means write.
- apb_pwdata  out  32  APB write data.
- apb_prdata  in  32  APB read data.
- apb_pready  in  1  APB ready.
- apb_pslverr  in  1  APB slave error.
- mem_error  out  1  error pulse; present only with DTI_APB_SLVERR_EN.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - A request sampled high at a clock edge latches address, size, data and direction, then moves to SETUP.
  - If both requests are high together, the write wins and the read is dropped.
- SETUP: psel=1, penable=0. Always moves to ACCESS after one cycle.
- ACCESS:
  - psel=1, penable=1.
  - Stays while pready=0; there are no wait-state limits.
  - When pready=1 at an edge, completes the transfer and returns to IDLE.
- Requests arriving in SETUP or ACCESS are ignored and not queued.
- apb_paddr is the full, unaligned latched address.
- Write lane replication:
  - byte: pwdata = {4{data[7:0]}}.
  - halfword: pwdata = {2{data[15:0]}}.
  - word: pwdata = data.
- Read extraction, applied at completion:
  - byte: prdata byte lane addr[1:0], zero-extended.
  - halfword: lane addr[1], zero-extended.
  - word: prdata unchanged.
- mem_data_out is registered and holds until the next read completes. Writes do not change it.
- Acks are registered and high for exactly one cycle after the completing edge; the FSM is back in IDLE during that cycle.
- pslverr is ignored unless the macro is enabled.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- After a transfer, apb_paddr, apb_pwrite and apb_pwdata hold their last values. psel and penable return to 0.
- Cycle sequence with pready already high:
  - request sampled at edge E0;
  - SETUP during E0..E1;
  - ACCESS during E1..E2, with pready sampled at E2;
  - ack high during E2..E3.
- Minimum latency is 3 cycles from request to ack. Each wait state adds 1 cycle.
- A new request is accepted in the ack cycle, giving back-to-back transfers every 3 cycles.
- Reset asserted mid-transfer aborts it immediately: psel, penable and the acks go to 0, no ack is issued, and the FSM returns to IDLE.

## Configuration
- Macro DTI_APB_SLVERR_EN.
- Defined:
  - port mem_error exists;
  - pslverr is sampled with pready at completion;
  - mem_error pulses in the same cycle as the ack;
  - on a read error, mem_data_out is loaded with 0.
- Undefined: no mem_error port, pslverr unused, read data always loaded.

## Structure
- Shared package dti_apb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS);
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
- Global macros come from dti_global_defines.svh.
- One natural sub-module, dti_apb_lane_align: combinational write replication and read lane extraction/zero-extension.

## Test plan
- Halfword write: addr 0x100, data 0xAB, size 01, write pulse; pready=1 once penable=1 -> paddr 0x100, pwrite=1, pwdata 0x00AB00AB, mem_write_ack one cycle, psel/penable drop.
- Word read with 2 wait states: addr 0x200, prdata 0xDEADBEEF -> penable held 3 cycles, mem_data_out 0xDEADBEEF, mem_read_ack pulse at 5 cycles.
- Byte read: addr 0x203, prdata 0x11223344 -> mem_data_out 0x00000011.
- Simultaneous read and write requests at addr 0x10 -> a single write transfer and only mem_write_ack. A request pulse during ACCESS is ignored.
- Reset asserted in ACCESS -> all outputs 0 asynchronously, no ack; the next request works normally.
- With DTI_APB_SLVERR_EN: read with pslverr=1 and prdata 0xFFFFFFFF -> mem_error and mem_read_ack pulse together, mem_data_out 0.
